// File: rtl/state_dump_reader.sv
// state_dump_reader: streams the register file, then a wrapping window of
// data memory, out over a valid/ready port tagged with source and index.
module state_dump_reader #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           dmem_base,
  input  logic [ADDR_W:0]             dmem_count,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]           rf_rdata,
  output logic [ADDR_W-1:0]           dmem_raddr,
  input  logic [DATA_W-1:0]           dmem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_tag,
  output logic [ADDR_W-1:0]           out_index,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned     RF_AW     = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0] LAST_REG  = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DMEM_WORDS);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    REGS,
    MEM,
    DRAIN
  } state_e;

  state_e              state_q;
  logic [ADDR_W:0]     idx_q;
  logic [ADDR_W:0]     idx_d;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   base_q;
  logic                out_valid_q;
  logic                out_tag_q;
  logic                done_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_index_q;
  logic                slot_free;
  logic [ADDR_W-1:0]   mem_addr;

  // Output slot may take a new word when empty or being emptied this edge.
  assign slot_free = !out_valid_q || out_ready;
  // Truncating add gives the wrap past the top of data memory.
  assign mem_addr  = base_q + idx_q[ADDR_W-1:0];
  assign idx_d     = idx_q + ONE;

  assign rf_raddr   = idx_q[RF_AW-1:0];
  assign dmem_raddr = mem_addr;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_index  = out_index_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // Dump sequencer with registered output slot and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        idx_q       <= '0;
        count_q     <= '0;
        base_q      <= '0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              base_q  <= dmem_base;
              count_q <= (dmem_count > MAX_COUNT) ? MAX_COUNT : dmem_count;
              idx_q   <= '0;
              state_q <= REGS;
            end
          end
          REGS: begin
            if (slot_free) begin
              out_valid_q <= 1'b1;
              out_data_q  <= rf_rdata;
              out_tag_q   <= 1'b0;
              out_index_q <= idx_q[ADDR_W-1:0];
              if (idx_q == LAST_REG) begin
                idx_q   <= '0;
                state_q <= (count_q == '0) ? DRAIN : MEM;
              end else begin
                idx_q <= idx_d;
              end
            end
          end
          MEM: begin
            if (slot_free) begin
              out_valid_q <= 1'b1;
              out_data_q  <= dmem_rdata;
              out_tag_q   <= 1'b1;
              out_index_q <= mem_addr;
              idx_q       <= idx_d;
              if (idx_q == count_q - ONE) begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (out_valid_q && out_ready) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
